majority_arbiter: RTL
=====================

# majority_arbiter

Round-robin arbiter and sequencer that shares one combinational `majority` voter among R requesters. Each requester presents an N-bit vote vector with a level request. The block grants one requester at a time, registers the granted vector into the voter, and returns the registered verdict with a one-cycle acknowledge. It sits between the vote-producing agents and the single `majority` instance.

## Interface
- `N`, 8: vote vector width; passed to `majority` as `n`; N ≥ 1.
- `R`, 4: number of requesters; R ≥ 2.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  R  per-requester request level.
- `vec`  in  R*N  flattened vote vectors; requester i occupies bits [i*N +: N].
- `ack`  out  R  one-hot, one-cycle acknowledge to the served requester.
- `res_valid`  out  1  high in the same cycle as `ack`.
- `res`  out  1  majority verdict for the served vector.
- `res_id`  out  clog2(R)  index of the served requester; valid with `res_valid`.
- `busy`  out  1  high in GRANT-to-RESP cycles (EVAL and RESP).

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE, `req` == 0:
  - Stay in IDLE.
- IDLE, `req` != 0:
  - Select g = first set `req` bit searching from `ptr` upward, wrapping modulo R.
  - Capture `vec[g]` into `x_q` and g into `g_q`.
  - Go to EVAL.
- EVAL:
  - `majority` evaluates `x_q` combinationally.
  - Register its `y` into `y_q`.
  - Go to RESP.
- RESP:
  - Assert `ack[g_q]`, `res_valid`, `res` = `y_q`, `res_id` = `g_q`.
  - Set `ptr` ← (g_q + 1) mod R.
  - Go to IDLE.
- Majority rule, inherited from `majority`:
  - `res` = 1 iff popcount(vector) > N/2.
  - Ties for even N resolve to 0.
- Requester protocol:
  - Hold `req` high and `vec` stable until `ack`.
  - Deassert `req` in the cycle after `ack`. Any `req` still high in IDLE is a new request.
- Vector sampling: `vec` is sampled only in the IDLE grant cycle. Changes after that have no effect on the verdict.
- Dropped request: if `req[g]` drops before RESP, the transaction still completes and `ack[g]` still pulses.
- Requester arrival: a request that arrives during EVAL or RESP waits for the next IDLE. No request is lost while its `req` stays high.
- Fairness: `ptr` rotates past the last served index. With all R requesting continuously, each is served once per R grants.
- `rst` in any state:
  - Next state IDLE, `ptr` = 0.
  - Any in-flight transaction is abandoned with no `ack`.

## Timing
- Reset values:
  - `ack` = 0, `res_valid` = 0, `res` = 0, `res_id` = 0, `busy` = 0.
  - `ptr` = 0, `x_q` = 0, `y_q` = 0.
- Outputs `ack`, `res_valid`, `res`, `res_id` are registered. They are driven as 0 outside RESP.
- Latency: `req` sampled high in IDLE at cycle t gives `ack` at cycle t+2.
- Throughput: one grant per 3 cycles under continuous load. The next IDLE grant is at t+3.
- `busy` is high exactly in the EVAL and RESP cycles.

## Structure
- Shared package holds:
  - State enum {IDLE, EVAL, RESP}.
  - Localparam `ID_W` = clog2(R), with a minimum of 1.
- Sub-modules:
  - `majority` (existing): instantiated once with `n` = N, driven from `x_q`.
  - One new sub-module, `rr_arbiter`: combinational pick of the first set bit from `ptr` with wrap. Inputs `req` and `ptr`; outputs one-hot grant and index.
- `ptr` and the FSM live in `majority_arbiter`.

## Test plan
- Single requester: from reset, `req` = 4'b0001, `vec[0]` = 8'b11111000. Expect `ack` = 4'b0001 at t+2, `res` = 1, `res_id` = 0, and `busy` high in t+1 and t+2.
- Tie: `req[1]` with `vec[1]` = 8'b11110000. Expect `res` = 0 at t+2, `res_id` = 1. Repeat with 8'b10101010; expect `res` = 0.
- All four requesting: from reset, `req` = 4'b1111 with vecs FF, 00, 0F, FE.
  - Expect acks for 0, 1, 2, 3 at cycles 2, 5, 8, 11.
  - Expect `res` = 1, 0, 0, 1.
- Fairness: `req[0]` and `req[2]` held continuously, each re-raised after `ack`. Expect service order 0, 2, 0, 2, with `ptr` advancing past each served index.
- Reset mid-operation: assert `rst` during EVAL. Expect:
  - No `ack`, and all outputs 0 the next cycle.
  - With `req` = 4'b1010 held, the next grant goes to requester 1 (`ptr` = 0).
- Odd width and late vector change: N = 5, `vec[0]` = 5'b00111.
  - Expect `res` = 1.
  - Change `vec[0]` to 0 during EVAL; `res` must still be 1.

Source files
------------

// File: rtl/majority_arbiter_pkg.sv
// ============================================================================
// majority_arbiter_pkg : shared FSM states and sizing helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package majority_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width for r requesters, never narrower than one bit.
  function automatic int id_width(input int r);
    return (r > 2) ? $clog2(r) : 1;
  endfunction

  localparam int DEFAULT_R = 4;
  localparam int ID_W      = id_width(DEFAULT_R);

endpackage

`default_nettype wire

// File: rtl/majority.sv
// ============================================================================
// majority : combinational voter, y = 1 iff more than half of x is set
// Revision 1.0
// ============================================================================
`default_nettype none

module majority #(
  parameter int n = 8
) (
  input  logic [n-1:0] x,
  output logic         y
);

  // Even-width ties fall to 0 because the comparison is strict.
  assign y = ($countones(x) > (n / 2));

endmodule

`default_nettype wire

// File: rtl/majority_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : first set request at or above ptr, wrapping modulo R
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import majority_arbiter_pkg::*;
#(
  parameter int R   = 4,
  parameter int IDW = id_width(R)
) (
  input  logic [R-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [R-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           valid_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < R; k++) begin
      cand = IDW'((int'(ptr_i) + k) % R);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/majority_arbiter.sv
// ============================================================================
// majority_arbiter : round-robin sharing of one majority voter among R agents
// Revision 1.0
// ============================================================================
`default_nettype none

module majority_arbiter
  import majority_arbiter_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int R   = 4,
  localparam int IDW = id_width(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_i,
  input  logic [R*N-1:0] vec_i,
  output logic [R-1:0]   ack_o,
  output logic           res_valid_o,
  output logic           res_o,
  output logic [IDW-1:0] res_id_o,
  output logic           busy_o
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] g_q, g_d;
  logic [N-1:0]   x_q, x_d;
  logic           y_q, y_d;
  logic [R-1:0]   ack_q, ack_d;
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_valid;
  logic [N-1:0]   masked [R];
  logic [N-1:0]   sel_vec;
  logic           maj_y;

  rr_arbiter #(
    .R   (R),
    .IDW (IDW)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // One-hot grant steers the winning vector through an AND-OR mux.
  for (genvar i = 0; i < R; i++) begin : g_mask
    assign masked[i] = vec_i[i*N +: N] & {N{gnt[i]}};
  end

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < R; i++) begin
      sel_vec = sel_vec | masked[i];
    end
  end

  majority #(
    .n (N)
  ) u_majority (
    .x (x_q),
    .y (maj_y)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    x_d         = x_q;
    y_d         = y_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_id_d    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          x_d     = sel_vec;
          g_d     = gnt_idx;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Response fields are loaded here so they appear registered in RESP.
        y_d         = maj_y;
        ack_d       = R'(1) << g_q;
        res_valid_d = 1'b1;
        res_id_d    = g_q;
        state_d     = RESP;
      end
      RESP: begin
        ptr_d   = (g_q == IDW'(R - 1)) ? '0 : g_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      x_q         <= '0;
      y_q         <= 1'b0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
    end
  end

  assign ack_o       = ack_q;
  assign res_valid_o = res_valid_q;
  assign res_o       = y_q & res_valid_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire
